// File: rtl/emesh_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | emesh_pkg                                                                |
// | Shared emesh constants: packet width, channel ids, packet field offsets. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package emesh_pkg;

   localparam int PW_DEFAULT = 104;

   localparam int CH_WR = 0;
   localparam int CH_RD = 1;
   localparam int CH_RR = 2;

   // Field offsets (LSB positions) inside a 104-bit emesh packet
   localparam int F_WRITE    = 0;
   localparam int F_DATAMODE = 1;
   localparam int W_DATAMODE = 2;
   localparam int F_CTRLMODE = 4;
   localparam int W_CTRLMODE = 4;
   localparam int F_DSTADDR  = 8;
   localparam int F_DATA     = 40;
   localparam int F_SRCADDR  = 72;
   localparam int W_ADDR     = 32;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_grant                                                                 |
// | Combinational round-robin picker: first request at or above ptr, wrapping.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_grant #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   int   w_base;
   int   w_cand;
   logic w_found;

   // Compare against constant loop indices so nothing is ever indexed >= N
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      w_base  = int'(ptr_i);
      if (w_base >= N) w_base = 0;
      for (int k = 0; k < N; k++) begin
         w_cand = w_base + k;
         if (w_cand >= N) w_cand = w_cand - N;
         for (int j = 0; j < N; j++) begin
            if (en_i && !w_found && (j == w_cand) && req_i[j]) begin
               gnt_o[j] = 1'b1;
               idx_o    = IW'(j);
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/emesh_chan_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | emesh_chan_arb                                                           |
// | N-channel round-robin emesh arbiter with one registered output stage.    |
// | Optional macro EMESH_ARB_STATS_EN adds per-channel saturating grant      |
// | counters on port grant_count.                                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module emesh_chan_arb
   import emesh_pkg::*;
#(
   parameter int NCHAN = 3,
   parameter int PW    = PW_DEFAULT,
   parameter int IDW   = 3
) (
   input  logic                clkin,
   input  logic                hard_reset,
   input  logic [NCHAN-1:0]    in_access,
   input  logic [NCHAN*PW-1:0] in_packet,
   output logic [NCHAN-1:0]    in_wait,
   output logic                out_access,
   output logic [PW-1:0]       out_packet,
   output logic [IDW-1:0]      out_chan,
   input  logic                out_wait
`ifdef EMESH_ARB_STATS_EN
   ,
   output logic [NCHAN*16-1:0] grant_count
`endif
);

   localparam int PTRW = $clog2(NCHAN);

   if ((2 ** IDW) < NCHAN) begin : g_bad_idw
      $error("emesh_chan_arb: IDW too narrow for NCHAN");
   end

   logic             out_access_q, out_access_d;
   logic [PW-1:0]    out_packet_q, out_packet_d;
   logic [IDW-1:0]   out_chan_q,   out_chan_d;
   logic [PTRW-1:0]  ptr_q,        ptr_d;

   logic             can_load;
   logic [NCHAN-1:0] gnt;
   logic [PTRW-1:0]  gnt_idx;
   logic [PW-1:0]    pkt_sel;

   assign can_load = ~out_access_q | ~out_wait;

   rr_grant #(
      .N  (NCHAN),
      .IW (PTRW)
   ) u_rr_grant (
      .req_i (in_access),
      .ptr_i (ptr_q),
      .en_i  (can_load),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign in_wait = in_access & ~gnt;

   always_comb begin
      pkt_sel = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (gnt[i]) pkt_sel = in_packet[i*PW +: PW];
      end
   end

   // A new grant replaces the output even while it drains: no bubble
   always_comb begin
      out_access_d = out_access_q;
      out_packet_d = out_packet_q;
      out_chan_d   = out_chan_q;
      ptr_d        = ptr_q;
      if (|gnt) begin
         out_access_d = 1'b1;
         out_packet_d = pkt_sel;
         out_chan_d   = IDW'(gnt_idx);
         ptr_d        = PTRW'(wrap_inc(int'(gnt_idx), NCHAN));
      end else if (!out_wait) begin
         out_access_d = 1'b0;
      end
   end

   always_ff @(posedge clkin) begin
      if (hard_reset) begin
         out_access_q <= 1'b0;
         out_packet_q <= '0;
         out_chan_q   <= '0;
         ptr_q        <= '0;
      end else begin
         out_access_q <= out_access_d;
         out_packet_q <= out_packet_d;
         out_chan_q   <= out_chan_d;
         ptr_q        <= ptr_d;
      end
   end

   assign out_access = out_access_q;
   assign out_packet = out_packet_q;
   assign out_chan   = out_chan_q;

`ifdef EMESH_ARB_STATS_EN
   for (genvar i = 0; i < NCHAN; i++) begin : g_stats
      logic [15:0] cnt_q;
      always_ff @(posedge clkin) begin
         if (hard_reset) begin
            cnt_q <= '0;
         end else if (gnt[i] && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
      assign grant_count[i*16 +: 16] = cnt_q;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_emesh_chan_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_emesh_chan_arb                                                        |
// | Directed-vector bench for emesh_chan_arb (NCHAN=3, PW=104, IDW=3).       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_emesh_chan_arb;

   localparam int NCHAN = 3;
   localparam int PW    = 104;
   localparam int IDW   = 3;

   logic                clkin;
   logic                hard_reset;
   logic [NCHAN-1:0]    in_access;
   logic [NCHAN*PW-1:0] in_packet;
   logic [NCHAN-1:0]    in_wait;
   logic                out_access;
   logic [PW-1:0]       out_packet;
   logic [IDW-1:0]      out_chan;
   logic                out_wait;
`ifdef EMESH_ARB_STATS_EN
   logic [NCHAN*16-1:0] grant_count;
`endif

   int n_vec;
   int n_err;

   emesh_chan_arb #(
      .NCHAN (NCHAN),
      .PW    (PW),
      .IDW   (IDW)
   ) dut (
      .clkin       (clkin),
      .hard_reset  (hard_reset),
      .in_access   (in_access),
      .in_packet   (in_packet),
      .in_wait     (in_wait),
      .out_access  (out_access),
      .out_packet  (out_packet),
      .out_chan    (out_chan),
      .out_wait    (out_wait)
`ifdef EMESH_ARB_STATS_EN
      ,
      .grant_count (grant_count)
`endif
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic acc, input logic [PW-1:0] pkt,
                          input logic [IDW-1:0] ch);
      chk({tag, ".acc"},  128'(out_access), 128'(acc));
      chk({tag, ".pkt"},  128'(out_packet), 128'(pkt));
      chk({tag, ".chan"}, 128'(out_chan),   128'(ch));
   endtask

   localparam logic [PW-1:0] PA = 104'hA0;
   localparam logic [PW-1:0] PB = 104'hB0;
   localparam logic [PW-1:0] PC = 104'hC0;

   initial begin
      n_vec      = 0;
      n_err      = 0;
      hard_reset = 1'b1;
      out_wait   = 1'b0;
      in_access  = 3'b111;
      in_packet  = {PC, PB, PA};

      // reset held for two edges
      tick();
      chk("rst0.acc", 128'(out_access), 128'(0));
      tick();
      chk_out("rst1", 1'b0, '0, '0);
      hard_reset = 1'b0;
      #1;
      chk("rst.in_wait", 128'(in_wait), 128'(3'b110));

      // round robin, one packet per cycle
      tick(); chk_out("rr0", 1'b1, PA, 3'd0);
      tick(); chk_out("rr1", 1'b1, PB, 3'd1);
      tick(); chk_out("rr2", 1'b1, PC, 3'd2);
      tick(); chk_out("rr3", 1'b1, PA, 3'd0);

      // output stall with channel 1 requesting (ptr = 1)
      in_access = 3'b010;
      out_wait  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("stall%0d.in_wait", k), 128'(in_wait), 128'(3'b010));
         tick();
         chk_out($sformatf("stall%0d", k), 1'b1, PA, 3'd0);
      end
      out_wait = 1'b0;
      #1;
      chk("unstall.in_wait", 128'(in_wait), 128'(3'b000));
      tick(); chk_out("unstall", 1'b1, PB, 3'd1);
      in_access = 3'b000;
      tick(); chk_out("drain", 1'b0, PB, 3'd1);

      // single sparse pulse on channel 2
      in_packet = {104'h55, PB, PA};
      in_access = 3'b100;
      #1;
      chk("sparse.in_wait", 128'(in_wait), 128'(3'b000));
      tick(); chk_out("sparse", 1'b1, 104'h55, 3'd2);
      in_access = 3'b000;
      tick(); chk_out("sparse.idle", 1'b0, 104'h55, 3'd2);

      // ptr = 0: channels 1,2 request -> 1 wins
      in_packet = {PC, PB, PA};
      in_access = 3'b110;
      #1;
      chk("prio.in_wait", 128'(in_wait), 128'(3'b100));
      tick(); chk_out("prio", 1'b1, PB, 3'd1);
      // ptr = 2: channels 0,1 request -> wraps to 0
      in_access = 3'b011;
      #1;
      chk("wrap.in_wait", 128'(in_wait), 128'(3'b010));
      tick(); chk_out("wrap", 1'b1, PA, 3'd0);

      // reset while stalled with a valid output (ptr = 1 before reset)
      in_access = 3'b000;
      out_wait  = 1'b1;
      tick(); chk_out("prerst", 1'b1, PA, 3'd0);
      hard_reset = 1'b1;
      tick(); chk_out("midrst", 1'b0, '0, '0);
      hard_reset = 1'b0;
      out_wait   = 1'b0;
      tick(); chk("postrst.acc", 128'(out_access), 128'(0));
      in_access = 3'b011;
      #1;
      chk("postrst.in_wait", 128'(in_wait), 128'(3'b010));
      tick(); chk_out("postrst", 1'b1, PA, 3'd0);

`ifdef EMESH_ARB_STATS_EN
      hard_reset = 1'b1;
      in_access  = 3'b000;
      tick();
      chk("stats.rst", 128'(grant_count), 128'(0));
      hard_reset = 1'b0;
      in_access  = 3'b001;
      for (int k = 0; k < 70000; k++) tick();
      in_access = 3'b010;
      for (int k = 0; k < 3; k++) tick();
      in_access = 3'b100;
      for (int k = 0; k < 2; k++) tick();
      in_access = 3'b000;
      tick();
      chk("stats.ch0", 128'(grant_count[15:0]),  128'(16'hFFFF));
      chk("stats.ch1", 128'(grant_count[31:16]), 128'(16'd3));
      chk("stats.ch2", 128'(grant_count[47:32]), 128'(16'd2));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/emesh_chan_arb.md
Name: emesh_chan_arb

Overview:
- Parametrised N-channel emesh transaction arbiter; generalises the fixed three-channel elink transmit side (txwr/txrd/txrr access/packet/wait) to NCHAN channels of width PW.
- Merges the channels into one registered output stream toward the elink TX serialiser.
- Uses round-robin grant and elink wait-style back-pressure, and is one-cycle pipelined.

Parameters:
- NCHAN, 3: number of input channels (2..8).
- PW, 104: emesh packet width in bits.
- IDW, 3: width of the channel-id output; must satisfy 2**IDW >= NCHAN.

Ports:
- clkin  in  1  single clock; all logic is on the rising edge.
- hard_reset  in  1  synchronous, active-high reset.
- in_access  in  NCHAN  per-channel request; bit i belongs to channel i.
- in_packet  in  NCHAN*PW  channel i occupies bits [i*PW +: PW].
- in_wait  out  NCHAN  per-channel back-pressure to the senders.
- out_access  out  1  registered output-valid.
- out_packet  out  PW  registered output packet.
- out_chan  out  IDW  channel id of the packet currently on out_packet.
- out_wait  in  1  downstream back-pressure.

Behaviour:
- Transfer rules:
  - Input transfer on channel i occurs in a cycle where in_access[i]=1 and in_wait[i]=0.
  - Output transfer occurs in a cycle where out_access=1 and out_wait=0.
- Senders hold access and packet stable while their wait is high; the block must not depend on this for correctness.
- Internal signals:
  - can_load = ~out_access | ~out_wait.
  - grant = one-hot round-robin choice among in_access, searching from index ptr upward with wrap at NCHAN-1 -> 0.
  - grant is all-zero if can_load=0 or in_access=0.
- in_wait[i] = in_access[i] & ~grant[i]. This is combinational and has no dependency from in_wait back to in_access.
- in_wait[i] = 0 when in_access[i] = 0.
- Each clock edge:
  - If grant != 0: out_packet <= selected packet, out_chan <= granted index, out_access <= 1, ptr <= granted index + 1 (wrapping NCHAN-1 -> 0).
  - Else if out_wait=0: out_access <= 0. out_packet and out_chan hold their values.
  - Else: hold everything.
- Latency is 1 cycle from input transfer to out_access.
- Sustained throughput is 1 packet/cycle when out_wait=0.
- Fairness: with all channels requesting continuously, grants cycle 0,1,..,NCHAN-1,0. No channel waits more than NCHAN-1 grants.
- Output stall: while out_access=1 and out_wait=1, out_packet/out_chan are frozen, all requesting channels see in_wait=1, and ptr does not move.
- Simultaneous drain+load: when out_wait=0 and a new grant occurs in the same cycle, the output is replaced back-to-back with no bubble.
- Reset values: out_access=0, out_packet=0, out_chan=0, ptr=0.
- Reset mid-transfer drops the registered packet. in_wait follows the combinational rule immediately after reset; since can_load=1, a requester is granted in the first post-reset cycle.
- in_access bits for indices >= NCHAN do not exist. The ptr comparison must not index past NCHAN-1.

Optional Feature:
- Macro: EMESH_ARB_STATS_EN.
- When defined, adds output port grant_count (NCHAN*16 bits).
  - Per-channel 16-bit counters increment on each grant to that channel.
  - Counters saturate at 16'hFFFF.
  - Counters reset to 0 on hard_reset.
  - Counters do not affect arbitration.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package emesh_pkg:
  - PW default constant.
  - Channel index constants: CH_WR=0, CH_RD=1, CH_RR=2.
  - Packet field offsets: access/write bit, datamode, ctrlmode, dstaddr, data, srcaddr.
- One sub-module: rr_grant.
  - Parameter N; inputs req[N], ptr, enable; output one-hot gnt[N] and encoded index.
  - Purely combinational, so it can be reused by the RX-side demux.

Test Plan:
- Reset: with hard_reset held 2 cycles and in_access=3'b111, out_access=0 during reset. First post-reset edge emits channel 0 (out_chan=0). in_wait=3'b110 in the cycle before that edge.
- Round-robin: all 3 channels request continuously with unique packets 0xA0/0xB0/0xC0 and out_wait=0. Output sequence is 0xA0,0xB0,0xC0,0xA0, one packet per cycle, out_chan 0,1,2,0.
- Output stall: out_wait=1 for 4 cycles while out_access=1 and channel 1 requests. out_packet is frozen and in_wait[1]=1 throughout. The cycle out_wait drops, channel 1 is granted and appears on the next edge with no gap.
- Single sparse channel: only channel 2 pulses access for 1 cycle with packet 0x55. out_access=1 with out_packet=0x55 and out_chan=2 one cycle later, then out_access=0.
- Reset mid-operation: hard_reset asserted while out_access=1 and out_wait=1. The next edge gives out_access=0 and ptr=0. The packet is not re-emitted.
- Stats (EMESH_ARB_STATS_EN): 70000 grants to channel 0 give grant_count[0]=16'hFFFF; other channel counts equal their grant totals.
